// File: rtl/multicycle_ctrl_v2_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle controller.
//   - opcode field values understood by the decoder
//   - ALU operation classes, alu_src_b and pc_source mux encodings
//   - 4-bit FSM state encoding (also exported on state_dbg)
package ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] J      = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_v2_if.sv
// Controller <-> datapath bundle.
//   master (controller): samples opcode/mem_ready/resume, drives all
//   datapath controls plus status (halted, trap, instr_count, state_dbg).
//   slave (datapath/bench): the mirror image.
interface multicycle_ctrl_v2_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                resume;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                ir_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                reg_write;
  logic                reg_dst;
  logic [1:0]          pc_source;
  logic                halted;
  logic                trap;
  logic [CNT_W-1:0]    instr_count;
  logic [3:0]          state_dbg;

  modport master (
    input  opcode, mem_ready, resume,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           mem_to_reg, ir_write, alu_src_a, alu_src_b, alu_op, reg_write,
           reg_dst, pc_source, halted, trap, instr_count, state_dbg
  );

  modport slave (
    output opcode, mem_ready, resume,
    input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           mem_to_reg, ir_write, alu_src_a, alu_src_b, alu_op, reg_write,
           reg_dst, pc_source, halted, trap, instr_count, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_v2_retire_counter.sv
// retire_counter: CNT_W-bit counter, +1 when en is high, wraps naturally.
//   clk, rst_n (async active-low clear), en, count.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2: Moore FSM sequencing fetch/decode/execute/memory/
// writeback for a single-memory MIPS-subset datapath.
//   clk, resetn (async active-low)
//   bus (master): opcode, mem_ready, resume in; datapath controls,
//   halted, trap, instr_count, state_dbg out.
// Controls decode from the state register alone (plus opcode in DECODE/
// BRANCH and mem_ready in FETCH), so an async reset drops every write
// enable the instant the state register clears.
module multicycle_ctrl_v2
  import ctrl_pkg::*;
#(
  parameter int                  OPCODE_W = 6,
  parameter int                  ALUOP_W  = 2,
  parameter int                  CNT_W    = 16,
  parameter logic [OPCODE_W-1:0] HALT_OP  = '1
) (
  input  logic clk,
  input  logic resetn,
  multicycle_ctrl_v2_if.master bus
);
  state_t state;
  logic   retire;

  function automatic logic op_is(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
    return op == OPCODE_W'(code);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if      (op_is(bus.opcode, R_TYPE))                          state <= S_EXEC_R;
          else if (op_is(bus.opcode, ADDI))                            state <= S_EXEC_I;
          else if (op_is(bus.opcode, LW) || op_is(bus.opcode, SW))     state <= S_MEM_ADDR;
          else if (op_is(bus.opcode, BEQ) || op_is(bus.opcode, BNE))   state <= S_BRANCH;
          else if (op_is(bus.opcode, J))                               state <= S_JUMP;
          else if (bus.opcode == HALT_OP)                              state <= S_HALT;
          else                                                         state <= S_TRAP;
        end
        S_EXEC_R:   state <= S_WB_R;
        S_WB_R:     state <= S_FETCH;
        S_EXEC_I:   state <= S_WB_I;
        S_WB_I:     state <= S_FETCH;
        // opcode is still the one decoded; anything but LW is treated as SW
        S_MEM_ADDR: state <= op_is(bus.opcode, LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state <= S_WB_MEM;
        S_WB_MEM:   state <= S_FETCH;
        S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     if (bus.resume) state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // an instruction retires on the edge that leaves its final state
  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR:                                   retire = bus.mem_ready;
      default:                                    retire = 1'b0;
    endcase
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst_n (resetn),
    .en    (retire),
    .count (bus.instr_count)
  );

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_op        = ALUOP_W'(ALU_ADD);
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.pc_source     = PCSRC_ALU;
    bus.halted        = 1'b0;
    bus.trap          = 1'b0;
    bus.state_dbg     = state;
    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        // IR load and PC+4 only on the cycle memory delivers the word
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
      S_EXEC_R, S_WB_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_W'(ALU_FUNCT);
        bus.reg_dst   = (state == S_WB_R);
        bus.reg_write = (state == S_WB_R);
      end
      S_EXEC_I, S_WB_I, S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.reg_write = (state == S_WB_I);
      end
      S_MEM_RD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_W'(ALU_SUB);
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.branch_ne     = op_is(bus.opcode, BNE);
      end
      S_JUMP: begin
        bus.pc_source = PCSRC_JUMP;
        bus.pc_write  = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      S_TRAP:  bus.trap   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
module tb_multicycle_ctrl_v2;
  localparam int CW = 3;  // narrow counter so wrap is reachable quickly

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_v2_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(CW)) bus ();

  multicycle_ctrl_v2 #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(CW), .HALT_OP(6'b111111)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string          tag;
    logic [18:0]    ctl;
    logic [3:0]     st;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // ctl bit order: pcw pcwc bne iord mr mw m2r irw asa asb[2] aop[2] rw rd pcs[2] h t
  function automatic logic [18:0] mk(input logic pcw, pcwc, bne, iord, mr, mw, m2r, irw, asa,
                                     input logic [1:0] asb, aop, input logic rw, rd,
                                     input logic [1:0] pcs, input logic h, t);
    return {pcw, pcwc, bne, iord, mr, mw, m2r, irw, asa, asb, aop, rw, rd, pcs, h, t};
  endfunction

  localparam logic [18:0] C_FW   = mk(0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_FR   = mk(1,0,0,0,1,0,0,1,0,2'b01,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_DEC  = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_EXR  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00,0,0);
  localparam logic [18:0] C_WBR  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,1,1,2'b00,0,0);
  localparam logic [18:0] C_EXI  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_WBI  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,1,0,2'b00,0,0);
  localparam logic [18:0] C_MA   = C_EXI;
  localparam logic [18:0] C_MRD  = mk(0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_WBM  = mk(0,0,0,0,0,0,1,0,0,2'b00,2'b00,1,0,2'b00,0,0);
  localparam logic [18:0] C_MWR  = mk(0,0,0,1,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,0,0);
  localparam logic [18:0] C_BNE  = mk(0,1,1,0,0,0,0,0,1,2'b00,2'b01,0,0,2'b01,0,0);
  localparam logic [18:0] C_BEQ  = mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,0,0,2'b01,0,0);
  localparam logic [18:0] C_JMP  = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b10,0,0);
  localparam logic [18:0] C_HLT  = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,1,0);
  localparam logic [18:0] C_TRP  = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,1);

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_J = 6'b000010, OP_HALT = 6'b111111, OP_BAD = 6'b110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] obs_ctl();
    return {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.iord, bus.mem_read,
            bus.mem_write, bus.mem_to_reg, bus.ir_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.reg_write, bus.reg_dst, bus.pc_source, bus.halted, bus.trap};
  endfunction

  task automatic check_out();
    exp_t e;
    chk("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, ".ctl"},   32'(obs_ctl()),         32'(e.ctl));
    chk({e.tag, ".state"}, 32'(bus.state_dbg),     32'(e.st));
    chk({e.tag, ".count"}, 32'(bus.instr_count),   32'(e.cnt));
  endtask

  // drive one cycle's inputs, queue what the outputs must be, compare,
  // then advance to just after the next rising edge
  task automatic step(input string tag, input logic [5:0] opc, input logic rdy, input logic res,
                      input logic [18:0] c, input logic [3:0] s, input logic [CW-1:0] n);
    exp_t e;
    bus.opcode = opc; bus.mem_ready = rdy; bus.resume = res;
    e.tag = tag; e.ctl = c; e.st = s; e.cnt = n;
    sb.push_back(e);
    #1;
    check_out();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.resume = 1'b0;
    #2;
    // reset state
    sb.push_back('{"reset", C_FW, 4'd0, CW'(0)});
    check_out();
    #10 resetn = 1'b1;  // t=12, away from edges

    // ADDI with mem_ready high throughout; resume in WB_I must be ignored
    step("addi.fetch",  OP_ADDI, 1, 0, C_FR,  4'd0, 3'd0);
    step("addi.decode", OP_ADDI, 1, 0, C_DEC, 4'd1, 3'd0);
    step("addi.exec",   OP_ADDI, 1, 0, C_EXI, 4'd4, 3'd0);
    step("addi.wb",     OP_ADDI, 1, 1, C_WBI, 4'd5, 3'd0);
    step("fetch.wait",  OP_LW,   0, 0, C_FW,  4'd0, 3'd1);

    // LW with three wait states in MEM_RD
    step("lw.fetch",    OP_LW, 1, 0, C_FR,  4'd0, 3'd1);
    step("lw.decode",   OP_LW, 0, 0, C_DEC, 4'd1, 3'd1);
    step("lw.addr",     OP_LW, 1, 0, C_MA,  4'd6, 3'd1);
    for (int i = 0; i < 3; i++) step("lw.rd_wait", OP_LW, 0, 0, C_MRD, 4'd7, 3'd1);
    step("lw.rd_done",  OP_LW, 1, 0, C_MRD, 4'd7, 3'd1);
    step("lw.wb",       OP_LW, 1, 0, C_WBM, 4'd8, 3'd1);

    // R-type
    step("r.fetch",  OP_R, 1, 0, C_FR,  4'd0, 3'd2);
    step("r.decode", OP_R, 1, 0, C_DEC, 4'd1, 3'd2);
    step("r.exec",   OP_R, 1, 0, C_EXR, 4'd2, 3'd2);
    step("r.wb",     OP_R, 1, 0, C_WBR, 4'd3, 3'd2);

    // BNE then BEQ
    step("bne.fetch",  OP_BNE, 1, 0, C_FR,  4'd0, 3'd3);
    step("bne.decode", OP_BNE, 1, 0, C_DEC, 4'd1, 3'd3);
    step("bne.branch", OP_BNE, 1, 0, C_BNE, 4'd10, 3'd3);
    step("beq.fetch",  OP_BEQ, 1, 0, C_FR,  4'd0, 3'd4);
    step("beq.decode", OP_BEQ, 1, 0, C_DEC, 4'd1, 3'd4);
    step("beq.branch", OP_BEQ, 1, 0, C_BEQ, 4'd10, 3'd4);

    // J
    step("j.fetch",  OP_J, 1, 0, C_FR,  4'd0, 3'd5);
    step("j.decode", OP_J, 1, 0, C_DEC, 4'd1, 3'd5);
    step("j.jump",   OP_J, 1, 0, C_JMP, 4'd11, 3'd5);

    // SW with two wait states
    step("sw.fetch",  OP_SW, 1, 0, C_FR,  4'd0, 3'd6);
    step("sw.decode", OP_SW, 1, 0, C_DEC, 4'd1, 3'd6);
    step("sw.addr",   OP_SW, 0, 0, C_MA,  4'd6, 3'd6);
    step("sw.wait",   OP_SW, 0, 0, C_MWR, 4'd9, 3'd6);
    step("sw.wait",   OP_SW, 0, 0, C_MWR, 4'd9, 3'd6);
    step("sw.done",   OP_SW, 1, 0, C_MWR, 4'd9, 3'd6);

    // HALT: frozen count for 10 cycles, then resume
    step("halt.fetch",  OP_HALT, 1, 0, C_FR,  4'd0, 3'd7);
    step("halt.decode", OP_HALT, 1, 0, C_DEC, 4'd1, 3'd7);
    for (int i = 0; i < 10; i++) step("halt.hold", OP_HALT, 1, 0, C_HLT, 4'd12, 3'd7);
    step("halt.resume", OP_HALT, 1, 1, C_HLT, 4'd12, 3'd7);

    // J after resume wraps the 3-bit counter 7 -> 0
    step("j2.fetch",  OP_J, 1, 0, C_FR,  4'd0, 3'd7);
    step("j2.decode", OP_J, 1, 0, C_DEC, 4'd1, 3'd7);
    step("j2.jump",   OP_J, 1, 0, C_JMP, 4'd11, 3'd7);

    // one R-type so the count is nonzero before the mid-access reset
    step("r2.fetch",  OP_R, 1, 0, C_FR,  4'd0, 3'd0);
    step("r2.decode", OP_R, 1, 0, C_DEC, 4'd1, 3'd0);
    step("r2.exec",   OP_R, 1, 0, C_EXR, 4'd2, 3'd0);
    step("r2.wb",     OP_R, 1, 0, C_WBR, 4'd3, 3'd0);

    // reset pulsed in the middle of a MEM_WR wait
    step("sw2.fetch",  OP_SW, 1, 0, C_FR,  4'd0, 3'd1);
    step("sw2.decode", OP_SW, 0, 0, C_DEC, 4'd1, 3'd1);
    step("sw2.addr",   OP_SW, 0, 0, C_MA,  4'd6, 3'd1);
    step("sw2.wait",   OP_SW, 0, 0, C_MWR, 4'd9, 3'd1);
    chk("sw2.mem_write_pre", 32'(bus.mem_write), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid.mem_write", 32'(bus.mem_write),   32'd0);
    chk("rst_mid.state",     32'(bus.state_dbg),   32'd0);
    chk("rst_mid.count",     32'(bus.instr_count), 32'd0);
    #1 resetn = 1'b1;

    // illegal opcode traps; resume has no effect
    step("bad.fetch",  OP_BAD, 1, 0, C_FR,  4'd0, 3'd0);
    step("bad.decode", OP_BAD, 1, 0, C_DEC, 4'd1, 3'd0);
    for (int i = 0; i < 3; i++) step("trap.hold", OP_BAD, 1, 1, C_TRP, 4'd13, 3'd0);
    resetn = 1'b0;
    #1;
    chk("trap_rst.trap",  32'(bus.trap),      32'd0);
    chk("trap_rst.state", 32'(bus.state_dbg), 32'd0);
    #2 resetn = 1'b1;

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
